// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives instruction memory and buffers fetched words
// in a 2-entry FIFO towards decode. Optional halt-on-sentinel via FETCH_CTRL_HALT_EN.
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

`ifdef FETCH_CTRL_HALT_EN
    localparam logic [31:0] SENTINEL = 32'h0FFF_FFFF;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        pop;
    logic        push;
    logic        no_sentinel;

    assign pop = out_valid & out_ready;

`ifdef FETCH_CTRL_HALT_EN
    logic halted_q;
    assign no_sentinel = (mem_instr != SENTINEL);
    assign halted      = halted_q;
`else
    assign no_sentinel = 1'b1;
    assign halted      = 1'b0;
`endif

    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign push = (state == RUN) & ~redirect_valid & no_sentinel & ((count != 2'd2) | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= PC_RESET;
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            buf_instr[0] <= 32'h0;
            buf_instr[1] <= 32'h0;
            buf_pc[0]    <= 32'h0;
            buf_pc[1]    <= 32'h0;
`ifdef FETCH_CTRL_HALT_EN
            halted_q     <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Flush: whatever decode accepted this cycle is already gone, the rest is dropped.
            pc    <= redirect_pc;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            state <= fetch_en ? RUN : IDLE;
`ifdef FETCH_CTRL_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            if (pop) begin
                head <= ~head;
            end
            if (push) begin
                buf_instr[tail] <= mem_instr;
                buf_pc[tail]    <= pc;
                tail            <= ~tail;
                pc              <= pc + PC_STEP;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef FETCH_CTRL_HALT_EN
                    if (!no_sentinel) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else
`endif
                    if (!fetch_en) begin
                        state <= IDLE;
                    end
                end
`ifdef FETCH_CTRL_HALT_EN
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
`endif
            endcase
        end
    end

    assign mem_addr  = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? buf_instr[head] : 32'h0;
    assign out_pc    = out_valid ? buf_pc[head] : 32'h0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-based reference model tracks the expected
// buffer contents, PC and halt status; a negedge monitor compares the DUT against it.
module tb_fetch_ctrl;

    localparam logic [31:0] STEP = 32'h1000_0000;
    localparam logic [31:0] SENT = 32'h0FFF_FFFF;
`ifdef FETCH_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [10];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 28);
        return (idx < 10) ? mem[idx] : SENT;
    endfunction

    assign mem_instr = mem_word(mem_addr);

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as {instr, pc} pairs.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_run = 1'b0;
    bit          m_halt = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                exp_q.delete();
                m_pc   = 32'h0;
                m_run  = 1'b0;
                m_halt = 1'b0;
            end else begin
                logic [31:0] w;
                w = mem_word(m_pc);
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (redirect_valid) begin
                    exp_q.delete();
                    m_pc   = redirect_pc;
                    m_run  = fetch_en;
                    m_halt = 1'b0;
                end else if (m_run) begin
                    if (HALT_EN && w == SENT) begin
                        m_run  = 1'b0;
                        m_halt = 1'b1;
                    end else begin
                        if (exp_q.size() < 2) begin
                            exp_q.push_back({w, m_pc});
                            m_pc = m_pc + STEP;
                        end
                        if (!fetch_en) m_run = 1'b0;
                    end
                end else if (!m_halt && fetch_en) begin
                    m_run = 1'b1;
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("mem_addr", mem_addr, m_pc);
                chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
                chk("halted", {31'h0, halted}, {31'h0, m_halt});
                if (exp_q.size() != 0) begin
                    chk("out_pc", out_pc, exp_q[0][31:0]);
                    chk("out_instr", out_instr, exp_q[0][63:32]);
                end else begin
                    chk("out_pc_idle", out_pc, 32'h0);
                    chk("out_instr_idle", out_instr, 32'h0);
                end
            end
        end
    end

    task automatic cyc(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_pc"}, out_pc, 32'h0);
        chk({tag, "_instr"}, out_instr, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            mem[i] = $urandom();
            if (mem[i] == SENT) mem[i] = 32'h1234_0000 + 32'(i);
        end
        #3;
        reset_check("reset");
        @(negedge clk);
        rst = 1'b1;

        // Streaming with decode always ready
        repeat (8) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // Back-pressure from the first fetch after reset
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_addr", mem_addr, 32'h2000_0000);
        chk("stall_head", out_pc, 32'h0);
        repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with a full buffer
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h5000_0000, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_flush", {31'h0, out_valid}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_pc", out_pc, 32'h5000_0000);
        chk("redir_instr", out_instr, mem[5]);

        // Run into the out-of-range sentinel
        cyc(1'b1, 1'b1, 32'h8000_0000, 1'b1);
        repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("sent_halted", {31'h0, halted}, {31'h0, HALT_EN});
        if (HALT_EN) chk("sent_addr", mem_addr, 32'hA000_0000);
        cyc(1'b1, 1'b1, 32'h0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk("resume_halted", {31'h0, halted}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 15) << 28);
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), rpc,
                ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset with a full buffer
        cyc(1'b1, 1'b1, 32'h0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_full", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b0;
        #1 reset_check("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
